// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared pipeline types, encodings and constants
package pipeline_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } hz_state_e;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t BUBBLE_CTRL = '0;

  // $zero is never a real producer, so it never creates a dependency
  function automatic logic dst_match(input logic [4:0] dst, input logic [4:0] src);
    return (dst != REG_ZERO) && (dst == src);
  endfunction

endpackage

// File: rtl/hazard_fsm.sv
// rtl/hazard_fsm.sv - load-use / branch hazard detection, stall sequencing and perf counters
module hazard_fsm
  import pipeline_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             ifid_beq,
  input  logic             ifid_uses_rt,
  input  logic             ifid_is_store,
  input  logic             branch_taken,
  input  logic             idex_mem_read,
  input  logic             idex_reg_write,
  input  logic [4:0]       idex_dst,
  input  logic             exmem_mem_read,
  input  logic [4:0]       exmem_dst,
  output logic             stall,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  hz_state_e  state, state_n;
  logic [1:0] cnt, cnt_n;
  logic [1:0] req;
  logic       rs_ex, rt_ex, rs_mem, rt_mem;
  logic       need_lu, need_ba, need_bl1, need_bl2;
  logic       stall_raw;

  always_comb begin
    rs_ex  = dst_match(idex_dst, ifid_rs);
    rt_ex  = dst_match(idex_dst, ifid_rt);
    rs_mem = dst_match(exmem_dst, ifid_rs);
    rt_mem = dst_match(exmem_dst, ifid_rt);

    // a store whose only dependency is its data register gets it via the MEM forward
    need_lu  = idex_mem_read && (rs_ex || (ifid_uses_rt && rt_ex && !ifid_is_store));
    need_ba  = ifid_beq && idex_reg_write && !idex_mem_read && (rs_ex || rt_ex);
    need_bl1 = ifid_beq && idex_mem_read && (rs_ex || rt_ex);
    need_bl2 = ifid_beq && exmem_mem_read && (rs_mem || rt_mem);

    if (need_bl1)
      req = 2'd2;
    else if (need_lu || need_ba || need_bl2)
      req = 2'd1;
    else
      req = 2'd0;
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    stall_raw = 1'b0;
    case (state)
      RUN: begin
        if (req != 2'd0)
          stall_raw = 1'b1;
        if (req == 2'd2) begin
          state_n = STALL;
          cnt_n   = 2'd1;
        end
      end
      STALL: begin
        stall_raw = 1'b1;
        cnt_n     = cnt - 2'd1;
        if (cnt_n == 2'd0)
          state_n = RUN;
      end
    endcase
  end

  // while reset is held the front end must run freely and never flush
  always_comb begin
    stall      = rst_n && stall_raw;
    pc_write   = !stall;
    ifid_write = !stall;
    ifid_flush = rst_n && !stall && ifid_beq && branch_taken;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= 2'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      stall_count <= stall_count + {{(CNT_W-1){1'b0}}, stall};
      flush_count <= flush_count + {{(CNT_W-1){1'b0}}, ifid_flush};
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with bubble injection and hazard control
module id_ex_stage
  import pipeline_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        IFIDRs,
  input  logic [4:0]        IFIDRt,
  input  logic [4:0]        IFIDRd,
  input  logic              IFIDBeq,
  input  logic              IFIDUsesRt,
  input  logic              IFIDIsStore,
  input  logic              BranchTaken,
  input  logic              RegDst,
  input  logic              ALUSrc,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              RegWrite,
  input  logic              MemToReg,
  input  logic [1:0]        ALUOp,
  input  logic [DATA_W-1:0] RsData,
  input  logic [DATA_W-1:0] RtData,
  input  logic [DATA_W-1:0] Imm,
  input  logic              EXMEMMemRead,
  input  logic [4:0]        EXMEMDst,
  output logic [4:0]        IDEXRs,
  output logic [4:0]        IDEXRt,
  output logic [4:0]        IDEXDst,
  output logic              IDEXRegDst,
  output logic              IDEXALUSrc,
  output logic              IDEXMemRead,
  output logic              IDEXMemWrite,
  output logic              IDEXRegWrite,
  output logic              IDEXMemToReg,
  output logic [1:0]        IDEXALUOp,
  output logic [DATA_W-1:0] IDEXRsData,
  output logic [DATA_W-1:0] IDEXRtData,
  output logic [DATA_W-1:0] IDEXImm,
  output logic              PCWrite,
  output logic              IFIDWrite,
  output logic              IFIDFlush,
  output logic [CNT_W-1:0]  StallCount,
  output logic [CNT_W-1:0]  FlushCount
);

  ctrl_t id_ctrl, ex_ctrl, idex_ctrl;
  logic  stall;

  hazard_fsm #(.CNT_W(CNT_W)) u_hazard (
    .clk            (clk),
    .rst_n          (rst_n),
    .ifid_rs        (IFIDRs),
    .ifid_rt        (IFIDRt),
    .ifid_beq       (IFIDBeq),
    .ifid_uses_rt   (IFIDUsesRt),
    .ifid_is_store  (IFIDIsStore),
    .branch_taken   (BranchTaken),
    .idex_mem_read  (idex_ctrl.mem_read),
    .idex_reg_write (idex_ctrl.reg_write),
    .idex_dst       (IDEXDst),
    .exmem_mem_read (EXMEMMemRead),
    .exmem_dst      (EXMEMDst),
    .stall          (stall),
    .pc_write       (PCWrite),
    .ifid_write     (IFIDWrite),
    .ifid_flush     (IFIDFlush),
    .stall_count    (StallCount),
    .flush_count    (FlushCount)
  );

  always_comb begin
    id_ctrl            = BUBBLE_CTRL;
    id_ctrl.reg_dst    = RegDst;
    id_ctrl.alu_src    = ALUSrc;
    id_ctrl.mem_read   = MemRead;
    id_ctrl.mem_write  = MemWrite;
    id_ctrl.reg_write  = RegWrite;
    id_ctrl.mem_to_reg = MemToReg;
    id_ctrl.alu_op     = ALUOp;
    // a stalled instruction still moves its operands down, only its side effects are killed
    ex_ctrl = stall ? BUBBLE_CTRL : id_ctrl;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_ctrl  <= BUBBLE_CTRL;
      IDEXRs     <= REG_ZERO;
      IDEXRt     <= REG_ZERO;
      IDEXDst    <= REG_ZERO;
      IDEXRsData <= '0;
      IDEXRtData <= '0;
      IDEXImm    <= '0;
    end else begin
      idex_ctrl  <= ex_ctrl;
      IDEXRs     <= IFIDRs;
      IDEXRt     <= IFIDRt;
      IDEXDst    <= RegDst ? IFIDRd : IFIDRt;
      IDEXRsData <= RsData;
      IDEXRtData <= RtData;
      IDEXImm    <= Imm;
    end
  end

  always_comb begin
    IDEXRegDst   = idex_ctrl.reg_dst;
    IDEXALUSrc   = idex_ctrl.alu_src;
    IDEXMemRead  = idex_ctrl.mem_read;
    IDEXMemWrite = idex_ctrl.mem_write;
    IDEXRegWrite = idex_ctrl.reg_write;
    IDEXMemToReg = idex_ctrl.mem_to_reg;
    IDEXALUOp    = idex_ctrl.alu_op;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register of the 5-stage MIPS core, with integrated hazard control. Each cycle it latches decoded operands, register specifiers and control bits from ID into EX. Its IDEXRs/IDEXRt/IDEXDst/IDEXRegWrite/IDEXMemRead outputs feed the EX-stage forwarding logic. It detects load-use and branch-in-ID hazards, stalls PC and IF/ID, injects bubbles, and issues the IF/ID flush for taken branches.

## Interface
- DATA_W, 32, datapath width
- CNT_W, 32, performance counter width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous reset, active low
- IFIDRs, IFIDRt, IFIDRd  in  5 each  register fields of the instruction in ID
- IFIDBeq  in  1  instruction in ID is a branch resolved in ID
- IFIDUsesRt  in  1  instruction in ID reads rt as a source (R-type, beq, sw)
- IFIDIsStore  in  1  instruction in ID is sw
- BranchTaken  in  1  ID comparator result (valid only when IFIDBeq)
- RegDst, ALUSrc, MemRead, MemWrite, RegWrite, MemToReg  in  1 each  ID control
- ALUOp  in  2  ID ALU control
- RsData, RtData, Imm  in  DATA_W each  ID operands and sign-extended immediate
- EXMEMMemRead  in  1, EXMEMDst  in  5  state of the instruction in MEM
- IDEXRs, IDEXRt, IDEXDst  out  5 each  registered specifiers; IDEXDst = RegDst ? Rd : Rt
- IDEXRegDst..IDEXMemToReg, IDEXALUOp  out  registered control
- IDEXRsData, IDEXRtData, IDEXImm  out  DATA_W  registered operands
- PCWrite, IFIDWrite  out  1  low = hold PC / IF/ID
- IFIDFlush  out  1  zero the IF/ID register next edge
- StallCount, FlushCount  out  CNT_W  performance counters

## Operation
- Hazard conditions are evaluated only in RUN. All destination matches require Dst ≠ 0.
  - LU (load-use): IDEXMemRead ∧ (IDEXDst==IFIDRs ∨ (IFIDUsesRt ∧ IDEXDst==IFIDRt)). Exemption: an rt-only match with IFIDIsStore is not a hazard, because the MEM store-data forward covers it.
  - BA (branch after ALU op): IFIDBeq ∧ IDEXRegWrite ∧ ¬IDEXMemRead ∧ Dst match on Rs/Rt → 1 stall.
  - BL1 (branch after load in EX): IFIDBeq ∧ IDEXMemRead ∧ match → 2 stalls.
  - BL2 (branch after load in MEM): IFIDBeq ∧ EXMEMMemRead ∧ EXMEMDst match → 1 stall.
  - LU → 1 stall. When several conditions are true, the required count is their maximum.
- FSM states:
  - RUN: if the required count n > 0, assert stall this cycle. If n == 2, go to STALL with cnt = 1; otherwise stay in RUN.
  - STALL: assert stall, decrement cnt, return to RUN when cnt reaches 0.
- While stall is asserted:
  - PCWrite = IFIDWrite = 0.
  - ID/EX captures a bubble: all control bits 0, specifiers and data still captured.
  - BranchTaken is ignored and IFIDFlush = 0.
- When not stalled: PCWrite = IFIDWrite = 1 and IFIDFlush = IFIDBeq ∧ BranchTaken. The branch instruction itself proceeds into ID/EX normally.
- StallCount increments on every stalled cycle. FlushCount increments on every cycle with IFIDFlush high. Both wrap modulo 2^CNT_W.

## Timing
- The ID/EX register loads unconditionally on every rising edge of clk (data or bubble). Latency from ID to EX is 1 cycle.
- PCWrite, IFIDWrite and IFIDFlush are combinational from the FSM state and current inputs, and are valid in the same cycle the hazard is visible.
- The register file is write-first, so no stall is required for a WB-stage producer.
- Reset (rst_n low, asynchronous): FSM = RUN, cnt = 0, all ID/EX outputs 0, both counters 0. Combinational outputs in reset are PCWrite = IFIDWrite = 1 and IFIDFlush = 0. Reset asserted mid-stall abandons the stall immediately.
- A BL1 stall lasts exactly 2 cycles. On the third cycle the producer is in WB and the branch proceeds.

## Structure
- Shared package pipeline_pkg holds:
  - ALUOp encodings
  - REG_ZERO = 5'd0
  - hazard state enum {RUN, STALL}
  - a bubble-control constant (all zeros)
- One sub-module, hazard_fsm, contains the hazard conditions, stall count, FSM and counters. id_ex_stage contains the register and the bubble mux.

## Test plan
- lw $2,0($1) in EX; add $3,$2,$4 in ID → exactly 1 cycle with PCWrite = 0 and bubble control; then add enters EX with IDEXRs = 2; StallCount = 1.
- lw $2 in EX; sw $2,4($5) in ID (rt-only match) → no stall, PCWrite stays 1.
- lw $2 in EX; beq $2,$0 in ID → 2 stall cycles (state RUN → STALL → RUN), 2 bubbles, StallCount = 2; BranchTaken = 1 during the stall produces no flush.
- add $2 in EX; beq $2,$3 in ID with BranchTaken = 1 → 1 stall, then IFIDFlush = 1 for one cycle; FlushCount = 1.
- lw $0 in EX, add using $0 in ID → no stall.
- rst_n pulled low during the second BL1 stall cycle → outputs clear asynchronously and PCWrite = 1; after release the FSM is in RUN and the counters are 0.
